// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single-port memory: CPU-priority grant with a D-port
// starvation guard, fixed-latency strobe window, registered read data and one-cycle ack.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2,
    parameter int MAX_WAIT    = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    output logic              MemRead,
    output logic              MemWrite,
    input  logic [DATA_W-1:0] MemData,
    output logic              busy,
    output logic              owner
);

    localparam int LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [LAT_W-1:0]  LAT_ZERO = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t             state_r;
    logic [LAT_W-1:0]   lat_cnt_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic               we_r;

    logic               grant_valid_s;
    logic               grant_d_s;
    logic [WAIT_W-1:0]  wait_next_s;
    logic [ADDR_W-1:0]  sel_addr_s;
    logic [DATA_W-1:0]  sel_wdata_s;
    logic               sel_we_s;

    // Arbitration: D is forced once it has been passed over MAX_WAIT times in a row.
    always_comb begin
        grant_valid_s = c_req | d_req;
        if (d_req && (wait_cnt_r == WAIT_MAX)) begin
            grant_d_s = 1'b1;
        end else if (c_req) begin
            grant_d_s = 1'b0;
        end else begin
            grant_d_s = d_req;
        end
    end

    // Starvation counter update applied at each IDLE grant.
    always_comb begin
        if (!grant_d_s && d_req) begin
            if (wait_cnt_r == WAIT_MAX) begin
                wait_next_s = WAIT_MAX;
            end else begin
                wait_next_s = wait_cnt_r + WAIT_ONE;
            end
        end else begin
            wait_next_s = WAIT_ZERO;
        end
    end

    // Winner's request fields, latched into the memory-side registers on grant.
    always_comb begin
        if (grant_d_s) begin
            sel_addr_s  = d_addr;
            sel_wdata_s = d_wdata;
            sel_we_s    = d_we;
        end else begin
            sel_addr_s  = c_addr;
            sel_wdata_s = c_wdata;
            sel_we_s    = c_we;
        end
    end

    // Access sequencer: IDLE -> ACCESS (strobes for MEM_LATENCY cycles) -> ACK -> IDLE.
    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state_r    <= ST_IDLE;
            lat_cnt_r  <= LAT_ZERO;
            wait_cnt_r <= WAIT_ZERO;
            we_r       <= 1'b0;
            c_ack      <= 1'b0;
            d_ack      <= 1'b0;
            c_rdata    <= {DATA_W{1'b0}};
            d_rdata    <= {DATA_W{1'b0}};
            Address    <= {ADDR_W{1'b0}};
            WriteData  <= {DATA_W{1'b0}};
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    c_ack <= 1'b0;
                    d_ack <= 1'b0;
                    if (grant_valid_s) begin
                        Address    <= sel_addr_s;
                        WriteData  <= sel_wdata_s;
                        we_r       <= sel_we_s;
                        owner      <= grant_d_s;
                        wait_cnt_r <= wait_next_s;
                        lat_cnt_r  <= LAT_LOAD;
                        MemRead    <= ~sel_we_s;
                        MemWrite   <= sel_we_s;
                        busy       <= 1'b1;
                        state_r    <= ST_ACCESS;
                    end else begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        busy     <= 1'b0;
                        state_r  <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (lat_cnt_r == LAT_ZERO) begin
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                        c_ack    <= ~owner;
                        d_ack    <= owner;
                        if (!we_r) begin
                            if (owner) begin
                                d_rdata <= MemData;
                            end else begin
                                c_rdata <= MemData;
                            end
                        end else begin
                            c_rdata <= c_rdata;
                        end
                        state_r <= ST_ACK;
                    end else begin
                        lat_cnt_r <= lat_cnt_r - LAT_ONE;
                        state_r   <= ST_ACCESS;
                    end
                end
                ST_ACK: begin
                    c_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    c_ack    <= 1'b0;
                    d_ack    <= 1'b0;
                    MemRead  <= 1'b0;
                    MemWrite <= 1'b0;
                    busy     <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    mem_port_arbiter_checker u_checker (
        .clk       (Clock),
        .rst       (Resetn),
        .c_ack     (c_ack),
        .d_ack     (d_ack),
        .mem_read  (MemRead),
        .mem_write (MemWrite),
        .busy      (busy)
    );

endmodule

// Protocol invariants of the arbiter's memory and ack outputs.
module mem_port_arbiter_checker (
    input logic clk,
    input logic rst,
    input logic c_ack,
    input logic d_ack,
    input logic mem_read,
    input logic mem_write,
    input logic busy
);

    // The two strobes are mutually exclusive.
    strobe_excl_a: assert property (@(posedge clk) disable iff (rst)
        !(mem_read && mem_write));

    // Only one port is ever acknowledged.
    ack_excl_a: assert property (@(posedge clk) disable iff (rst)
        !(c_ack && d_ack));

    // Acks only appear while the arbiter is busy.
    ack_busy_a: assert property (@(posedge clk) disable iff (rst)
        (c_ack || d_ack) |-> busy);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected acks,
// a negedge monitor pops and compares port and read data on every ack.
module tb_mem_port_arbiter;

    localparam int L = 2;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_ack, d_ack;
    logic [31:0] c_rdata, d_rdata;
    logic [31:0] Address, WriteData, MemData;
    logic        MemRead, MemWrite, busy, owner;

    typedef struct {
        bit          port;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_c   = 32'h0;
    logic [31:0] last_d   = 32'h0;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .MAX_WAIT(4)
    ) dut (
        .Clock(Clock), .Resetn(Resetn),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .Address(Address), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemData(MemData),
        .busy(busy), .owner(owner)
    );

    always #5 Clock = ~Clock;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0040: rom = 32'h1234_5678;
            32'h0000_0044: rom = 32'h0BAD_F00D;
            32'h0000_0048: rom = 32'h55AA_55AA;
            default:       rom = 32'hA5A5_0000 ^ a;
        endcase
    endfunction

    assign MemData = rom(Address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every ack must match the oldest expected completion.
    always @(negedge Clock) begin
        if (c_ack || d_ack) begin
            check("ack_excl", 32'(c_ack & d_ack), 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack: c_ack=%0b d_ack=%0b with empty scoreboard at %0t",
                         c_ack, d_ack, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("ack_port", 32'(d_ack), 32'(mon_e.port));
                check("ack_rdata", mon_e.port ? d_rdata : c_rdata, mon_e.rdata);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_c_ack"}, 32'(c_ack), 32'd0);
        check({tag, "_d_ack"}, 32'(d_ack), 32'd0);
        check({tag, "_memread"}, 32'(MemRead), 32'd0);
        check({tag, "_memwrite"}, 32'(MemWrite), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_owner"}, 32'(owner), 32'd0);
        check({tag, "_address"}, Address, 32'd0);
        check({tag, "_wdata"}, WriteData, 32'd0);
        check({tag, "_c_rdata"}, c_rdata, 32'd0);
        check({tag, "_d_rdata"}, d_rdata, 32'd0);
    endtask

    // Single access from an idle arbiter with a cycle-exact strobe/ack check.
    task automatic run_access(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rd);
        exp_t e;
        bit   strobe;
        @(posedge Clock);
        #1;
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            c_req = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
        end
        if (!we) begin
            if (port) last_d = rd;
            else      last_c = rd;
        end
        e.port  = port;
        e.rdata = port ? last_d : last_c;
        sb_q.push_back(e);
        for (int cyc = 0; cyc <= L + 1; cyc++) begin
            @(negedge Clock);
            strobe = (cyc >= 1) && (cyc <= L);
            check("memread", 32'(MemRead), 32'(strobe && !we));
            check("memwrite", 32'(MemWrite), 32'(strobe && we));
            check("busy", 32'(busy), 32'(cyc != 0));
            check("c_ack", 32'(c_ack), 32'((cyc == L + 1) && !port));
            check("d_ack", 32'(d_ack), 32'((cyc == L + 1) && port));
            if (cyc >= 1) begin
                check("owner", 32'(owner), 32'(port));
                check("address", Address, addr);
                if (we) check("writedata", WriteData, wdata);
            end
        end
        @(posedge Clock);
        #1;
        if (port) d_req = 1'b0;
        else      c_req = 1'b0;
    endtask

    initial begin
        logic [7:0] busy_pat;
        logic [7:0] rd_pat;
        logic [7:0] own_pat;
        exp_t       e;

        Resetn = 1'b1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40; c_wdata = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44; d_wdata = 32'h0;

        // Reset with both requests high: everything stays zero.
        repeat (2) begin
            @(negedge Clock);
            check_all_zero("reset");
        end

        // After release C wins first; D follows in the next IDLE with busy low for one cycle.
        last_c = 32'h1234_5678;
        last_d = 32'h0BAD_F00D;
        e.port = 1'b0; e.rdata = last_c; sb_q.push_back(e);
        e.port = 1'b1; e.rdata = last_d; sb_q.push_back(e);
        busy_pat = 8'hEE;
        rd_pat   = 8'h66;
        own_pat  = 8'hE0;
        @(posedge Clock);
        #1;
        Resetn = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge Clock);
            check("rel_busy", 32'(busy), 32'(busy_pat[cyc]));
            check("rel_memread", 32'(MemRead), 32'(rd_pat[cyc]));
            check("rel_owner", 32'(owner), 32'(own_pat[cyc]));
            if (cyc == 3) c_req = 1'b0;
            if (cyc == 7) d_req = 1'b0;
        end

        // Plain C read, then D write leaving d_rdata untouched.
        run_access(1'b0, 1'b0, 32'h40, 32'h0, 32'h1234_5678);
        run_access(1'b1, 1'b1, 32'h80, 32'hDEAD_BEEF, 32'h0);

        // Both masters held: the starvation guard forces D every fifth grant.
        @(posedge Clock);
        #1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        for (int k = 0; k < 10; k++) begin
            e.port  = (k == 4) || (k == 9);
            e.rdata = e.port ? last_d : last_c;
            sb_q.push_back(e);
        end
        for (int n = 0; n < 200 && sb_q.size() != 0; n++) @(posedge Clock);
        check("fair_drained", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        #1;
        c_req = 1'b0;
        d_req = 1'b0;

        // Reset in the first ACCESS cycle aborts the access with no ack.
        @(posedge Clock);
        #1;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h48;
        @(posedge Clock);
        @(negedge Clock);
        check("abort_pre_memread", 32'(MemRead), 32'd1);
        Resetn = 1'b1;
        c_req  = 1'b0;
        repeat (2) begin
            @(negedge Clock);
            check_all_zero("abort");
        end
        last_c = 32'h0;
        last_d = 32'h0;
        @(posedge Clock);
        #1;
        Resetn = 1'b0;
        run_access(1'b0, 1'b0, 32'h48, 32'h0, 32'h55AA_55AA);
        run_access(1'b1, 1'b0, 32'h44, 32'h0, 32'h0BAD_F00D);

        repeat (3) @(negedge Clock);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
